// File: rtl/regfile_2w2r_init_if.sv
// Register-file access bundle: two write ports, two read ports and status flags.
interface regfile_2w2r_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite_a;
  logic [ADDR_WIDTH-1:0] Write_register_a;
  logic [DATA_WIDTH-1:0] Write_data_a;
  logic                  RegWrite_b;
  logic [ADDR_WIDTH-1:0] Write_register_b;
  logic [DATA_WIDTH-1:0] Write_data_b;
  logic [ADDR_WIDTH-1:0] Read_register1;
  logic [ADDR_WIDTH-1:0] Read_register2;
  logic [DATA_WIDTH-1:0] Read_data1;
  logic [DATA_WIDTH-1:0] Read_data2;
  logic                  init_busy;
  logic                  write_collision;

  // Pipeline side: issues writes and read addresses, consumes read data.
  modport master (
    output RegWrite_a, Write_register_a, Write_data_a,
    output RegWrite_b, Write_register_b, Write_data_b,
    output Read_register1, Read_register2,
    input  Read_data1, Read_data2, init_busy, write_collision
  );

  // Register-file side.
  modport slave (
    input  RegWrite_a, Write_register_a, Write_data_a,
    input  RegWrite_b, Write_register_b, Write_data_b,
    input  Read_register1, Read_register2,
    output Read_data1, Read_data2, init_busy, write_collision
  );
endinterface

// File: rtl/regfile_2w2r_init.sv
// Two-write / two-read register file with a sequenced post-reset clear
// engine, optional same-cycle write-to-read bypass and a dual-write
// collision flag. Register 0 is hardwired to zero.
module regfile_2w2r_init #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SP_INDEX   = 29,
  parameter int SP_INIT    = 256,
  parameter int BYPASS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_2w2r_init_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, next_state;
  logic [ADDR_WIDTH-1:0] idx_q, next_idx;
  logic                  busy_q, next_busy;
  logic                  coll_q, next_coll;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Effective write enables: writes to register 0 are discarded.
  logic we_a, we_b;
  assign we_a = bus.RegWrite_a && (bus.Write_register_a != '0);
  assign we_b = bus.RegWrite_b && (bus.Write_register_b != '0);

  // Control state register; reset only rewinds the clear engine.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    state_q <= next_state;
    idx_q   <= next_idx;
    busy_q  <= next_busy;
    coll_q  <= next_coll;
  end

  // Next-state logic for the clear sequence and the collision pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    next_state = state_q;
    next_idx   = idx_q;
    next_busy  = busy_q;
    next_coll  = 1'b0;
    if (reset) begin
      next_state = CLEAR;
      next_idx   = ADDR_WIDTH'(1);
      next_busy  = 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          next_idx = idx_q + 1'b1;
          if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
            next_state = READY;
            next_busy  = 1'b0;
          end
        end
        READY: begin
          next_coll = we_a && we_b &&
                      (bus.Write_register_a == bus.Write_register_b);
        end
        default: next_state = CLEAR;
      endcase
    end
  end

  // Register array update: clear engine in CLEAR, ports A then B in READY
  // so that B wins a same-address write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the clear engine initialises it
    // one entry per cycle, keeping it mappable to plain RAM cells.
    if (!reset) begin
      if (state_q == CLEAR) begin
        regs[idx_q] <= (idx_q == ADDR_WIDTH'(SP_INDEX)) ?
                       DATA_WIDTH'(SP_INIT) : '0;
      end else if (state_q == READY) begin
        if (we_a) regs[bus.Write_register_a] <= bus.Write_data_a;
        if (we_b) regs[bus.Write_register_b] <= bus.Write_data_b;
      end
    end
  end

  // Read selection: zero during CLEAR and for r0, then bypass, then storage.
  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic                  ready,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  wa_en,
    input logic [ADDR_WIDTH-1:0] wa_addr,
    input logic [DATA_WIDTH-1:0] wa_data,
    input logic                  wb_en,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    if (!ready || addr == '0)                      return '0;
    if (BYPASS != 0 && wb_en && addr == wb_addr)   return wb_data;
    if (BYPASS != 0 && wa_en && addr == wa_addr)   return wa_data;
    return stored;
  endfunction

  logic [DATA_WIDTH-1:0] stored1, stored2, rd1, rd2;
  logic                  ready;

  // Combinational read ports.
  always_comb begin
    ready   = (state_q == READY);
    stored1 = regs[bus.Read_register1];
    stored2 = regs[bus.Read_register2];
    rd1 = read_mux(ready, bus.Read_register1, stored1,
                   we_a, bus.Write_register_a, bus.Write_data_a,
                   we_b, bus.Write_register_b, bus.Write_data_b);
    rd2 = read_mux(ready, bus.Read_register2, stored2,
                   we_a, bus.Write_register_a, bus.Write_data_a,
                   we_b, bus.Write_register_b, bus.Write_data_b);
  end

  assign bus.Read_data1      = rd1;
  assign bus.Read_data2      = rd2;
  assign bus.init_busy       = busy_q;
  assign bus.write_collision = coll_q;
endmodule
